scan_scroll_ctrl: RTL and testbench



---
 rtl/scan_scroll_ctrl.sv | 124 ++++++++++++
 tb/tb_scan_scroll_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_scroll_ctrl.sv
// Four-digit 7-segment scan sequencer: anode multiplexing with blanking dead-time,
// per-digit message fetch, and a scroll pointer that only moves on frame boundaries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | slot_cnt < BLANK_CYCLES: anodes off, character fetch in flight
// ST_SHOW  | remaining slot cycles: current digit's anode driven low
module scan_scroll_ctrl #(
  parameter int SLOT_CYCLES  = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int MSG_LEN      = 16,
  parameter int ADDR_W       = 4,
  parameter int AUTO_FRAMES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  input  logic              auto_en,
  input  logic [3:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        char,
  output logic              an3,
  output logic              an2,
  output logic              an1,
  output logic              an0,
  output logic [ADDR_W-1:0] base,
  output logic              frame_done
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [SW-1:0]     SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0]     BLANK_V   = SW'(BLANK_CYCLES);
  localparam logic [SW-1:0]     FETCH_V   = SW'(1);
  localparam logic [FW-1:0]     AUTO_LAST = FW'(AUTO_FRAMES - 1);
  localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]   MSG_LEN_V = (ADDR_W + 1)'(MSG_LEN);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  // MSG_LEN need not be a power of two, so wrap by a single compare-and-subtract.
  function automatic logic [ADDR_W-1:0] digit_index(input logic [ADDR_W-1:0] b,
                                                    input logic [1:0]        d);
    logic [ADDR_W:0] sum;
    sum = {1'b0, b} + {{(ADDR_W - 1){1'b0}}, 2'd3 - d};
    if (sum >= MSG_LEN_V) sum = sum - MSG_LEN_V;
    return sum[ADDR_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [1:0]        digit_q, digit_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              pending_q, pending_d;
  logic              btn_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        char_q, char_d;
  logic [3:0]        an_q, an_d;
  logic              fd_q, fd_d;
  logic              slot_wrap, at_frame_end, btn_rise, auto_step;

  always_comb begin
    slot_wrap    = (slot_q == SLOT_LAST);
    slot_d       = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d      = slot_wrap ? digit_q - 2'd1 : digit_q;
    at_frame_end = slot_wrap && (digit_q == 2'd0);
    btn_rise     = button & ~btn_q;
    auto_step    = auto_en && at_frame_end && (frame_q == AUTO_LAST);

    frame_d = frame_q;
    if (!auto_en)          frame_d = '0;
    else if (at_frame_end) frame_d = auto_step ? '0 : frame_q + 1'b1;

    // An edge on the boundary cycle itself folds into this boundary's step.
    pending_d = pending_q | btn_rise;
    base_d    = base_q;
    if (at_frame_end) begin
      if (pending_d || auto_step) base_d = (base_q == BASE_LAST) ? '0 : base_q + 1'b1;
      pending_d = 1'b0;
    end

    state_d = (slot_d < BLANK_V) ? ST_BLANK : ST_SHOW;
    an_d    = (state_d == ST_SHOW) ? ~(4'b0001 << digit_d) : 4'b1111;
    addr_d  = slot_wrap ? digit_index(base_d, digit_d) : addr_q;
    char_d  = (state_q == ST_BLANK && slot_q == FETCH_V) ? mem_data : char_q;
    fd_d    = (digit_d == 2'd0) && (slot_d == SLOT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BLANK;
      slot_q    <= '0;
      digit_q   <= 2'd3;
      frame_q   <= '0;
      pending_q <= 1'b0;
      btn_q     <= 1'b0;
      base_q    <= '0;
      addr_q    <= '0;
      char_q    <= 4'd0;
      an_q      <= 4'b1111;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      digit_q   <= digit_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      btn_q     <= button;
      base_q    <= base_d;
      addr_q    <= addr_d;
      char_q    <= char_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign mem_addr             = addr_q;
  assign char                 = char_q;
  assign {an3, an2, an1, an0} = an_q;
  assign base                 = base_q;
  assign frame_done           = fd_q;

endmodule

// File: tb/tb_scan_scroll_ctrl.sv
// Bench for scan_scroll_ctrl: frame/slot timing and scroll behaviour checked
// against a cycle-count reference model built from the display rules.
module tb_scan_scroll_ctrl;
  localparam int SLOT    = 16;
  localparam int BLANK   = 2;
  localparam int MSG_LEN = 16;
  localparam int AW      = 4;
  localparam int AUTO    = 8;
  localparam int FRAME   = 4 * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          button = 1'b0;
  logic          auto_en = 1'b0;
  logic [3:0]    mem_data = 4'd0;
  logic [AW-1:0] mem_addr;
  logic [3:0]    char;
  logic          an3, an2, an1, an0;
  logic [AW-1:0] base;
  logic          frame_done;
  logic [3:0]    an_v;

  logic [3:0] msg [MSG_LEN];

  int checks = 0;
  int errors = 0;

  // reference model state
  int   n, m_base, afc, slot, dig, exp_addr;
  bit   pend, prev_b;
  logic [3:0] exp_an, exp_char;
  logic exp_fd;

  scan_scroll_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .MSG_LEN(MSG_LEN),
                     .ADDR_W(AW), .AUTO_FRAMES(AUTO)) dut (
    .clk(clk), .reset(reset), .button(button), .auto_en(auto_en),
    .mem_data(mem_data), .mem_addr(mem_addr), .char(char),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .base(base), .frame_done(frame_done)
  );

  assign an_v = {an3, an2, an1, an0};

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= msg[mem_addr];

  function automatic void compute_exp();
    slot     = n % SLOT;
    dig      = 3 - (n / SLOT) % 4;
    exp_an   = (slot < BLANK) ? 4'hF : ~(4'b0001 << dig);
    exp_fd   = (dig == 0) && (slot == SLOT - 1);
    exp_addr = (m_base + 3 - dig) % MSG_LEN;
    exp_char = msg[exp_addr];
  endfunction

  // Drive inputs for the current cycle, take one edge, advance the model, settle.
  task automatic tick(input logic b, input logic a);
    bit rise, fire;
    button  = b;
    auto_en = a;
    @(posedge clk);
    rise   = b && !prev_b;
    prev_b = b;
    if (!a) afc = 0;
    if ((n % FRAME) == FRAME - 1) begin
      fire = 0;
      if (a) begin
        afc++;
        if (afc == AUTO) begin fire = 1; afc = 0; end
      end
      if (pend || rise || fire) m_base = (m_base + 1) % MSG_LEN;
      pend = 0;
    end else if (rise) begin
      pend = 1;
    end
    n++;
    compute_exp();
    #1;
  endtask

  task automatic do_reset();
    button  = 1'b0;
    auto_en = 1'b0;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    n = 0; m_base = 0; afc = 0; pend = 0; prev_b = 0;
    compute_exp();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (an_v !== 4'hF) begin errors++; $display("FAIL reset_anodes got %b want 1111", an_v); end
    checks++; if (char !== 4'd0) begin errors++; $display("FAIL reset_char got %0d want 0", char); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    checks++; if (base !== '0) begin errors++; $display("FAIL reset_base got %0d want 0", base); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_first_frame();
    logic [3:0] seq [4];
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 4'(i);
    do_reset();
    for (int c = 0; c < FRAME; c++) begin
      tick(1'b0, 1'b0);
      checks++; if (an_v !== exp_an) begin errors++; $display("FAIL first_frame_anodes n=%0d got %b want %b", n, an_v, exp_an); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL first_frame_fd n=%0d got %b want %b", n, frame_done, exp_fd); end
      if (slot == 0) begin
        checks++; if (mem_addr !== AW'(exp_addr)) begin errors++; $display("FAIL first_frame_addr n=%0d got %0d want %0d", n, mem_addr, exp_addr); end
      end
      if (slot == BLANK) seq[3 - dig] = char;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (seq[k] !== 4'(k)) begin errors++; $display("FAIL first_frame_char digit_pos=%0d got %0d want %0d", k, seq[k], k); end
    end
  endtask

  task automatic test_single_button();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick(c == 20, 1'b0);
      if (c == FRAME - 3) begin
        checks++; if (base !== AW'(0)) begin errors++; $display("FAIL single_btn_hold got %0d want 0", base); end
      end
      checks++; if (base !== AW'(m_base)) begin errors++; $display("FAIL single_btn_base n=%0d got %0d want %0d", n, base, m_base); end
      if (slot >= BLANK) begin
        checks++; if (char !== exp_char) begin errors++; $display("FAIL single_btn_char n=%0d got %0d want %0d", n, char, exp_char); end
      end
    end
    checks++; if (base !== AW'(1)) begin errors++; $display("FAIL single_btn_final got %0d want 1", base); end
  endtask

  task automatic test_multi_button();
    int b0;
    b0 = m_base;
    for (int c = 0; c < FRAME; c++) begin
      tick(c == 5 || c == 15 || c == 40, 1'b0);
      checks++; if (base !== AW'(m_base)) begin errors++; $display("FAIL multi_btn_base n=%0d got %0d want %0d", n, base, m_base); end
    end
    checks++; if (base !== AW'((b0 + 1) % MSG_LEN)) begin errors++; $display("FAIL multi_btn_step got %0d want %0d", base, (b0 + 1) % MSG_LEN); end
  endtask

  task automatic test_wrap();
    while (m_base != 14) for (int c = 0; c < FRAME; c++) tick(c == 10, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        tick(c == 10, 1'b0);
        if (slot >= BLANK) begin
          checks++; if (char !== exp_char) begin errors++; $display("FAIL wrap_char n=%0d got %0d want %0d", n, char, exp_char); end
        end
      end
      checks++; if (base !== AW'(f == 0 ? 15 : 0)) begin errors++; $display("FAIL wrap_base step=%0d got %0d want %0d", f, base, f == 0 ? 15 : 0); end
    end
  endtask

  task automatic test_auto();
    do_reset();
    for (int f = 0; f < 2 * AUTO; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        tick(f == AUTO - 1 && c == 30, 1'b1);
        checks++; if (base !== AW'(m_base)) begin errors++; $display("FAIL auto_base n=%0d got %0d want %0d", n, base, m_base); end
      end
      if (f == AUTO - 1) begin
        checks++; if (base !== AW'(1)) begin errors++; $display("FAIL auto_first_step got %0d want 1", base); end
      end
    end
    checks++; if (base !== AW'(2)) begin errors++; $display("FAIL auto_second_step got %0d want 2", base); end
  endtask

  task automatic test_back_to_back();
    int b0;
    while ((n % FRAME) != FRAME - 1) tick(1'b0, 1'b0);
    b0 = m_base;
    tick(1'b1, 1'b0);
    checks++; if (base !== AW'((b0 + 1) % MSG_LEN)) begin errors++; $display("FAIL boundary_edge got %0d want %0d", base, (b0 + 1) % MSG_LEN); end
    for (int c = 0; c < FRAME; c++) tick(c < 20, 1'b0);
    checks++; if (base !== AW'((b0 + 1) % MSG_LEN)) begin errors++; $display("FAIL held_button got %0d want %0d", base, (b0 + 1) % MSG_LEN); end
  endtask

  task automatic test_random();
    logic a;
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 4'($urandom_range(0, 15));
    do_reset();
    a = 1'b1;
    for (int c = 0; c < 40 * FRAME; c++) begin
      if ($urandom_range(0, 299) == 0) a = ~a;
      tick($urandom_range(0, 19) == 0, a);
      checks++; if (an_v !== exp_an) begin errors++; $display("FAIL rand_anodes n=%0d got %b want %b", n, an_v, exp_an); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL rand_fd n=%0d got %b want %b", n, frame_done, exp_fd); end
      checks++; if (base !== AW'(m_base)) begin errors++; $display("FAIL rand_base n=%0d got %0d want %0d", n, base, m_base); end
      if (slot >= BLANK) begin
        checks++; if (char !== exp_char) begin errors++; $display("FAIL rand_char n=%0d got %0d want %0d", n, char, exp_char); end
      end
    end
  endtask

  task automatic test_midslot_reset();
    do_reset();
    while (n != FRAME + 2 * SLOT + 7) tick(n == 10, 1'b0);
    checks++; if (an_v !== 4'b1101) begin errors++; $display("FAIL pre_reset_anodes got %b want 1101", an_v); end
    checks++; if (base !== AW'(1)) begin errors++; $display("FAIL pre_reset_base got %0d want 1", base); end
    #2 reset = 1'b0;
    #1;
    checks++; if (an_v !== 4'hF) begin errors++; $display("FAIL async_reset_anodes got %b want 1111", an_v); end
    checks++; if (base !== '0) begin errors++; $display("FAIL async_reset_base got %0d want 0", base); end
    checks++; if (char !== 4'd0) begin errors++; $display("FAIL async_reset_char got %0d want 0", char); end
    do_reset();
    for (int c = 0; c < FRAME; c++) begin
      tick(1'b0, 1'b0);
      checks++; if (an_v !== exp_an) begin errors++; $display("FAIL restart_anodes n=%0d got %b want %b", n, an_v, exp_an); end
      if (slot >= BLANK) begin
        checks++; if (char !== exp_char) begin errors++; $display("FAIL restart_char n=%0d got %0d want %0d", n, char, exp_char); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 4'(i);
    test_reset();
    test_first_frame();
    test_single_button();
    test_multi_button();
    test_wrap();
    test_back_to_back();
    test_auto();
    test_random();
    test_midslot_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
